// File: rtl/sys_cmd_ctrl_v2.sv
`default_nettype none
// ============================================================================
// sys_cmd_ctrl_v2 : framed UART command decoder for RF/ALU with serialised TX
// Revision: 1.0
// ============================================================================
module sys_cmd_ctrl_v2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_data_valid,
  input  logic [ALU_OUT_WIDTH-1:0] alu_out,
  input  logic                     alu_out_valid,
  input  logic                     tx_ready,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     wr_en,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_en,
  output logic [3:0]               alu_fun,
  output logic                     alu_en,
  output logic                     clk_gate_en,
  output logic                     clk_div_en,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  output logic                     cmd_error,
  output logic [1:0]               err_code,
  output logic                     busy
);

  localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CNTW   = (NBYTES > 1) ? $clog2(NBYTES + 1) : 1;
  localparam int TMOW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMOW-1:0] TMO_MAX = TMOW'(TIMEOUT_CYCLES);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_OPA      = 4'd5;
  localparam logic [3:0] S_OPB      = 4'd6;
  localparam logic [3:0] S_FUN      = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_SEND  = 4'd9;

  localparam logic [1:0] ERR_CMD  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  logic [3:0]               state;
  logic [3:0]               next_state;
  logic [TMOW-1:0]          tmo_cnt;
  logic [ALU_OUT_WIDTH-1:0] resp_buf;
  logic [CNTW-1:0]          rem;
  logic [7:0]               cmd_byte;

  logic                     collecting;
  logic                     counting;
  logic                     rx_acc;
  logic                     progress;
  logic                     tmo_expire;
  logic                     overrun;
  logic                     addr_bad;
  logic                     cmd_known;
  logic                     tx_xfer;
  logic                     tx_last;

  logic [ADDR_WIDTH-1:0]    addr_n;
  logic                     wr_en_n;
  logic [DATA_WIDTH-1:0]    wr_data_n;
  logic                     rd_en_n;
  logic [3:0]               alu_fun_n;
  logic                     alu_en_n;
  logic [DATA_WIDTH-1:0]    tx_data_n;
  logic [ALU_OUT_WIDTH-1:0] resp_buf_n;
  logic [CNTW-1:0]          rem_n;
  logic                     err_now;
  logic [1:0]               err_code_n;

  generate
    if (DATA_WIDTH >= 8) begin : g_cmd_wide
      assign cmd_byte = rx_data[7:0];
    end else begin : g_cmd_narrow
      assign cmd_byte = {{(8 - DATA_WIDTH){1'b0}}, rx_data};
    end
  endgenerate

  assign collecting = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_RD_ADDR) ||
                      (state == S_OPA) || (state == S_OPB) || (state == S_FUN);
  assign counting   = (state != S_IDLE) && (state != S_TX_SEND);
  assign rx_acc     = rx_valid && collecting;
  assign progress   = rx_acc ||
                      ((state == S_RD_WAIT) && rd_data_valid) ||
                      ((state == S_ALU_WAIT) && alu_out_valid);
  // An arriving byte (or response) on the expiry cycle takes precedence over the timeout.
  assign tmo_expire = (TIMEOUT_CYCLES > 0) && counting && (tmo_cnt == TMO_MAX) && !progress;
  assign overrun    = rx_valid && ((state == S_RD_WAIT) || (state == S_ALU_WAIT) ||
                                   (state == S_TX_SEND));
  assign addr_bad   = |(rx_data >> ADDR_WIDTH);
  assign cmd_known  = (cmd_byte == 8'hAA) || (cmd_byte == 8'hBB) ||
                      (cmd_byte == 8'hCC) || (cmd_byte == 8'hDD);
  assign tx_xfer    = (state == S_TX_SEND) && tx_valid && tx_ready;
  assign tx_last    = (rem == CNTW'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          case (cmd_byte)
            8'hAA:   next_state = S_WR_ADDR;
            8'hBB:   next_state = S_RD_ADDR;
            8'hCC:   next_state = S_OPA;
            8'hDD:   next_state = S_FUN;
            default: next_state = S_IDLE;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (rx_valid)        next_state = addr_bad ? S_IDLE : S_WR_DATA;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_WR_DATA: begin
        if (rx_valid || tmo_expire) next_state = S_IDLE;
      end
      S_RD_ADDR: begin
        if (rx_valid)        next_state = addr_bad ? S_IDLE : S_RD_WAIT;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_RD_WAIT: begin
        if (rd_data_valid)   next_state = S_TX_SEND;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_OPA: begin
        if (rx_valid)        next_state = S_OPB;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_OPB: begin
        if (rx_valid)        next_state = S_FUN;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_FUN: begin
        if (rx_valid)        next_state = S_ALU_WAIT;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_ALU_WAIT: begin
        if (alu_out_valid)   next_state = S_TX_SEND;
        else if (tmo_expire) next_state = S_IDLE;
      end
      S_TX_SEND: begin
        if (tx_xfer && tx_last) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    addr_n     = addr;
    wr_en_n    = 1'b0;
    wr_data_n  = wr_data;
    rd_en_n    = 1'b0;
    alu_fun_n  = alu_fun;
    alu_en_n   = 1'b0;
    tx_data_n  = tx_data;
    resp_buf_n = resp_buf;
    rem_n      = rem;
    err_now    = 1'b0;
    err_code_n = err_code;
    case (state)
      S_IDLE: begin
        if (rx_valid && !cmd_known) begin
          err_now    = 1'b1;
          err_code_n = ERR_CMD;
        end
      end
      S_WR_ADDR, S_RD_ADDR: begin
        if (rx_valid) begin
          addr_n = rx_data[ADDR_WIDTH-1:0];
          if (addr_bad) begin
            err_now    = 1'b1;
            err_code_n = ERR_ADDR;
          end else if (state == S_RD_ADDR) begin
            rd_en_n = 1'b1;
          end
        end
      end
      S_WR_DATA: begin
        if (rx_valid) begin
          wr_en_n   = 1'b1;
          wr_data_n = rx_data;
        end
      end
      S_OPA: begin
        if (rx_valid) begin
          wr_en_n   = 1'b1;
          wr_data_n = rx_data;
          addr_n    = ADDR_WIDTH'(OPA_ADDR);
        end
      end
      S_OPB: begin
        if (rx_valid) begin
          wr_en_n   = 1'b1;
          wr_data_n = rx_data;
          addr_n    = ADDR_WIDTH'(OPB_ADDR);
        end
      end
      S_FUN: begin
        if (rx_valid) begin
          alu_fun_n = rx_data[3:0];
          alu_en_n  = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (rd_data_valid) begin
          tx_data_n  = rd_data;
          resp_buf_n = '0;
          rem_n      = CNTW'(1);
        end
      end
      S_ALU_WAIT: begin
        if (alu_out_valid) begin
          tx_data_n  = alu_out[DATA_WIDTH-1:0];
          resp_buf_n = alu_out >> DATA_WIDTH;
          rem_n      = CNTW'(NBYTES);
        end
      end
      S_TX_SEND: begin
        // Shift the buffer so the next byte is always at the bottom.
        if (tx_xfer) begin
          tx_data_n  = resp_buf[DATA_WIDTH-1:0];
          resp_buf_n = resp_buf >> DATA_WIDTH;
          rem_n      = rem - CNTW'(1);
        end
      end
      default: ;
    endcase
    if (overrun || tmo_expire) begin
      err_now    = 1'b1;
      err_code_n = ERR_TMO;
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      resp_buf    <= '0;
      rem         <= '0;
      addr        <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      rd_en       <= 1'b0;
      alu_fun     <= '0;
      alu_en      <= 1'b0;
      clk_gate_en <= 1'b0;
      clk_div_en  <= 1'b1;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      cmd_error   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      if ((next_state != state) || rx_acc) begin
        tmo_cnt <= '0;
      end else if (counting && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + TMOW'(1);
      end
      resp_buf    <= resp_buf_n;
      rem         <= rem_n;
      addr        <= addr_n;
      wr_en       <= wr_en_n;
      wr_data     <= wr_data_n;
      rd_en       <= rd_en_n;
      alu_fun     <= alu_fun_n;
      alu_en      <= alu_en_n;
      clk_gate_en <= (next_state == S_FUN) || (next_state == S_ALU_WAIT);
      clk_div_en  <= 1'b1;
      tx_data     <= tx_data_n;
      tx_valid    <= (next_state == S_TX_SEND);
      cmd_error   <= err_now;
      err_code    <= err_code_n;
      busy        <= (next_state != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_ctrl_v2.sv
`default_nettype none
// ============================================================================
// tb_sys_cmd_ctrl_v2 : directed self-checking bench for sys_cmd_ctrl_v2
// Revision: 1.0
// ============================================================================
module tb_sys_cmd_ctrl_v2;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_data_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [3:0]  addr;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic        clk_gate_en;
  logic        clk_div_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        cmd_error;
  logic [1:0]  err_code;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sys_cmd_ctrl_v2 #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16),
    .TIMEOUT_CYCLES(TMO), .OPA_ADDR(0), .OPB_ADDR(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .tx_ready(tx_ready),
    .addr(addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .alu_fun(alu_fun), .alu_en(alu_en), .clk_gate_en(clk_gate_en),
    .clk_div_en(clk_div_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .cmd_error(cmd_error), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_clk_div_en", clk_div_en, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_wr_en", wr_en, 0);
    rst = 1'b0;
    cycle();

    // 1. RF write
    send(8'hAA);
    chk("wr_busy_cmd", busy, 1);
    send(8'h05);
    chk("wr_no_early_wr", wr_en, 0);
    send(8'h3C);
    chk("wr_en", wr_en, 1);
    chk("wr_addr", addr, 5);
    chk("wr_data", wr_data, 8'h3C);
    chk("wr_busy_done", busy, 0);
    chk("wr_no_tx", tx_valid, 0);
    cycle();
    chk("wr_en_one_cycle", wr_en, 0);

    // 2. RF read with back-pressure
    send(8'hBB);
    send(8'h05);
    chk("rd_en", rd_en, 1);
    chk("rd_addr", addr, 5);
    cycle();
    chk("rd_en_one_cycle", rd_en, 0);
    cycle();
    rd_data = 8'h3C;
    rd_data_valid = 1'b1;
    cycle();
    rd_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_tx_valid_held", tx_valid, 1);
      chk("rd_tx_data_held", tx_data, 8'h3C);
      if (i < 2) cycle();
    end
    tx_ready = 1'b1;
    cycle();
    chk("rd_tx_done", tx_valid, 0);
    chk("rd_busy_done", busy, 0);
    cycle();
    chk("rd_single_xfer", tx_valid, 0);
    tx_ready = 1'b0;

    // 3. ALU with operands
    send(8'hCC);
    send(8'h12);
    chk("opa_wr_en", wr_en, 1);
    chk("opa_addr", addr, 0);
    chk("opa_data", wr_data, 8'h12);
    send(8'h34);
    chk("opb_wr_en", wr_en, 1);
    chk("opb_addr", addr, 1);
    chk("opb_data", wr_data, 8'h34);
    chk("fun_clk_gate", clk_gate_en, 1);
    send(8'h01);
    chk("alu_en", alu_en, 1);
    chk("alu_fun", alu_fun, 1);
    chk("alu_wait_clk_gate", clk_gate_en, 1);
    cycle();
    chk("alu_en_one_cycle", alu_en, 0);
    alu_out = 16'hABCD;
    alu_out_valid = 1'b1;
    tx_ready = 1'b1;
    cycle();
    alu_out_valid = 1'b0;
    chk("alu_tx_b0_valid", tx_valid, 1);
    chk("alu_tx_b0", tx_data, 8'hCD);
    chk("alu_clk_gate_off", clk_gate_en, 0);
    cycle();
    chk("alu_tx_b1_valid", tx_valid, 1);
    chk("alu_tx_b1", tx_data, 8'hAB);
    cycle();
    chk("alu_tx_done", tx_valid, 0);
    chk("alu_busy_done", busy, 0);
    tx_ready = 1'b0;

    // 4. Errors
    send(8'h55);
    chk("badcmd_err", cmd_error, 1);
    chk("badcmd_code", err_code, 1);
    chk("badcmd_idle", busy, 0);
    cycle();
    chk("badcmd_pulse", cmd_error, 0);
    chk("badcmd_sticky", err_code, 1);
    send(8'hAA);
    send(8'h15);
    chk("badaddr_err", cmd_error, 1);
    chk("badaddr_code", err_code, 2);
    chk("badaddr_idle", busy, 0);
    chk("badaddr_no_wr", wr_en, 0);
    cycle();
    chk("badaddr_no_wr_late", wr_en, 0);

    // 5. Timeout
    send(8'hAA);
    repeat (TMO) cycle();
    chk("tmo_not_yet", busy, 1);
    chk("tmo_no_err_yet", cmd_error, 0);
    cycle();
    chk("tmo_err", cmd_error, 1);
    chk("tmo_code", err_code, 3);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_wr", wr_en, 0);
    send(8'hAA);
    repeat (TMO) cycle();
    send(8'h05);
    chk("tmo_edge_no_err", cmd_error, 0);
    chk("tmo_edge_busy", busy, 1);
    send(8'h77);
    chk("tmo_edge_wr_en", wr_en, 1);
    chk("tmo_edge_wr_data", wr_data, 8'h77);
    chk("tmo_edge_addr", addr, 5);

    // 6. Reset during 2nd TX byte, then overrun during ALU_WAIT
    send(8'hDD);
    chk("dd_clk_gate", clk_gate_en, 1);
    send(8'h02);
    chk("dd_alu_en", alu_en, 1);
    chk("dd_alu_fun", alu_fun, 2);
    alu_out = 16'h1234;
    alu_out_valid = 1'b1;
    tx_ready = 1'b1;
    cycle();
    alu_out_valid = 1'b0;
    chk("dd_tx_b0", tx_data, 8'h34);
    cycle();
    tx_ready = 1'b0;
    chk("dd_tx_b1", tx_data, 8'h12);
    chk("dd_tx_b1_valid", tx_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err_code", err_code, 0);
    rst = 1'b0;
    cycle();
    send(8'hCC);
    send(8'hAA);
    chk("post_rst_opa_wr", wr_en, 1);
    chk("post_rst_opa_addr", addr, 0);
    send(8'h55);
    send(8'h03);
    send(8'h99);
    chk("ovr_err", cmd_error, 1);
    chk("ovr_code", err_code, 3);
    chk("ovr_busy", busy, 1);
    alu_out = 16'hBEEF;
    alu_out_valid = 1'b1;
    tx_ready = 1'b1;
    cycle();
    alu_out_valid = 1'b0;
    chk("ovr_tx_b0", tx_data, 8'hEF);
    chk("ovr_tx_b0_valid", tx_valid, 1);
    chk("ovr_err_pulse", cmd_error, 0);
    cycle();
    chk("ovr_tx_b1", tx_data, 8'hBE);
    cycle();
    chk("ovr_tx_done", tx_valid, 0);
    chk("ovr_busy_done", busy, 0);
    tx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
